// File: rtl/axi_lite_memory_mock_pkg.sv
// Shared AXI4-Lite configuration for the memory mock: bus widths, response codes,
// channel FSM states and the address-region tag used by the decoder.
package axi_lite_memory_mock_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_PROT_WIDTH = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {RD_BOOT, RD_ADDR, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_BOOT, WR_COLLECT, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {REGION_NONE, REGION_D, REGION_I} region_t;

  function automatic logic [1:0] resp_for(input region_t region);
    return (region == REGION_NONE) ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_memory_mock_if.sv
// AXI4-Lite bus bundle between the core-side master and the memory mock.
interface axi_lite_memory_mock_if
  import axi_lite_memory_mock_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH
);
  logic                        S_AXI_AWVALID;
  logic                        S_AXI_AWREADY;
  logic [ADDR_WIDTH-1:0]       S_AXI_AWADDR;
  logic [AXI_PROT_WIDTH-1:0]   S_AXI_AWPROT;
  logic                        S_AXI_WVALID;
  logic                        S_AXI_WREADY;
  logic [DATA_WIDTH-1:0]       S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0]     S_AXI_WSTRB;
  logic                        S_AXI_BVALID;
  logic                        S_AXI_BREADY;
  logic [1:0]                  S_AXI_BRESP;
  logic                        S_AXI_ARVALID;
  logic                        S_AXI_ARREADY;
  logic [ADDR_WIDTH-1:0]       S_AXI_ARADDR;
  logic [AXI_PROT_WIDTH-1:0]   S_AXI_ARPROT;
  logic                        S_AXI_RVALID;
  logic                        S_AXI_RREADY;
  logic [DATA_WIDTH-1:0]       S_AXI_RDATA;
  logic [1:0]                  S_AXI_RRESP;

  modport master (
    output S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    output S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
    output S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
    input  S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP
  );

  modport slave (
    input  S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    input  S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
    input  S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
    output S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP
  );

endinterface

// File: rtl/axi_lite_memory_mock.sv
// AXI4-Lite slave modelling instruction (i_data) and data (d_data) memories.
// One outstanding read and one outstanding write; read data appears one cycle after AR.
module axi_lite_memory_mock
  import axi_lite_memory_mock_pkg::*;
#(
  parameter int                    ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = AXI_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] D_BASE     = 32'h0000_0000,
  parameter int                    D_DEPTH    = 1024,
  parameter logic [ADDR_WIDTH-1:0] I_BASE     = 32'h0000_1000,
  parameter int                    I_DEPTH    = 1024
)(
  input logic                   CLK,
  input logic                   RST,
  axi_lite_memory_mock_if.slave s_axi
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int DIW    = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1;
  localparam int IIW    = (I_DEPTH > 1) ? $clog2(I_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] D_SPAN = ADDR_WIDTH'(4 * D_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] I_SPAN = ADDR_WIDTH'(4 * I_DEPTH);

  // Not reset: contents survive RST so preloaded programs stay intact.
  logic [DATA_WIDTH-1:0] d_data [D_DEPTH];
  logic [DATA_WIDTH-1:0] i_data [I_DEPTH];

  rd_state_t             rd_state;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  wr_state_t             wr_state;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_dat;
  logic [STRB_W-1:0]     w_strb;
  logic                  commit;

  region_t               ar_region;
  region_t               aw_region;
  logic [DIW-1:0]        ar_d_idx;
  logic [IIW-1:0]        ar_i_idx;
  logic [DIW-1:0]        aw_d_idx;
  logic [IIW-1:0]        aw_i_idx;

  wire unused_prot = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  // Unsigned offset wraps for addresses below the base, so one compare bounds both ends.
  function automatic region_t decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] d_off;
    logic [ADDR_WIDTH-1:0] i_off;
    d_off = addr - D_BASE;
    i_off = addr - I_BASE;
    if (d_off < D_SPAN) return REGION_D;
    if (i_off < I_SPAN) return REGION_I;
    return REGION_NONE;
  endfunction

  assign ar_region = decode(s_axi.S_AXI_ARADDR);
  assign aw_region = decode(aw_addr);
  assign ar_d_idx  = DIW'((s_axi.S_AXI_ARADDR - D_BASE) >> 2);
  assign ar_i_idx  = IIW'((s_axi.S_AXI_ARADDR - I_BASE) >> 2);
  assign aw_d_idx  = DIW'((aw_addr - D_BASE) >> 2);
  assign aw_i_idx  = IIW'((aw_addr - I_BASE) >> 2);

  assign commit = (wr_state == WR_COLLECT) && aw_held && w_held;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_state  <= RD_BOOT;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      unique case (rd_state)
        RD_BOOT: begin
          arready_q <= 1'b1;
          rd_state  <= RD_ADDR;
        end
        RD_ADDR: begin
          if (s_axi.S_AXI_ARVALID) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rresp_q   <= resp_for(ar_region);
            unique case (ar_region)
              REGION_D: rdata_q <= d_data[ar_d_idx];
              REGION_I: rdata_q <= i_data[ar_i_idx];
              default:  rdata_q <= '0;
            endcase
            rd_state  <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (s_axi.S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rd_state  <= RD_ADDR;
          end
        end
        default: rd_state <= RD_BOOT;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_state  <= WR_BOOT;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr   <= '0;
      w_dat     <= '0;
      w_strb    <= '0;
    end else begin
      unique case (wr_state)
        WR_BOOT: begin
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          wr_state  <= WR_COLLECT;
        end
        WR_COLLECT: begin
          if (aw_held && w_held) begin
            bvalid_q <= 1'b1;
            bresp_q  <= resp_for(aw_region);
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            wr_state <= WR_RESP;
          end else begin
            if (awready_q && s_axi.S_AXI_AWVALID) begin
              aw_addr   <= s_axi.S_AXI_AWADDR;
              aw_held   <= 1'b1;
              awready_q <= 1'b0;
            end
            if (wready_q && s_axi.S_AXI_WVALID) begin
              w_dat    <= s_axi.S_AXI_WDATA;
              w_strb   <= s_axi.S_AXI_WSTRB;
              w_held   <= 1'b1;
              wready_q <= 1'b0;
            end
          end
        end
        WR_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wr_state  <= WR_COLLECT;
          end
        end
        default: wr_state <= WR_BOOT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb[b]) begin
          if (aw_region == REGION_D) d_data[aw_d_idx][8*b +: 8] <= w_dat[8*b +: 8];
          if (aw_region == REGION_I) i_data[aw_i_idx][8*b +: 8] <= w_dat[8*b +: 8];
        end
      end
    end
  end

  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;

endmodule

// File: tb/tb_axi_lite_memory_mock.sv
// Directed bench for axi_lite_memory_mock: reset, reads, strobed writes, split AW/W,
// out-of-range responses and reset during a pending read.
module tb_axi_lite_memory_mock;
  import axi_lite_memory_mock_pkg::*;

  logic CLK;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] rd;
  logic [1:0]  rs;
  logic [1:0]  bs;
  int          n;

  axi_lite_memory_mock_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_memory_mock dut (
    .CLK   (CLK),
    .RST   (RST),
    .s_axi (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_read(input string tag, input logic [31:0] addr,
                          output logic [31:0] data, output logic [1:0] resp);
    int k;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    k = 0;
    while (!bus.S_AXI_ARREADY && k < 20) begin
      tick();
      k++;
    end
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    check({tag, " rvalid one cycle after AR"}, 32'(bus.S_AXI_RVALID), 32'd1);
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    check({tag, " rvalid cleared"}, 32'(bus.S_AXI_RVALID), 32'd0);
    check({tag, " arready restored"}, 32'(bus.S_AXI_ARREADY), 32'd1);
  endtask

  task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int  k;
    bit  aw_done, w_done, aw_go, w_go;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    aw_done = 0;
    w_done  = 0;
    k = 0;
    while (!(aw_done && w_done) && k < 20) begin
      aw_go = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_go  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      tick();
      if (aw_go) begin bus.S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_go)  begin bus.S_AXI_WVALID  = 1'b0; w_done  = 1; end
      k++;
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    k = 0;
    while (!bus.S_AXI_BVALID && k < 20) begin
      tick();
      k++;
    end
    check({tag, " bvalid"}, 32'(bus.S_AXI_BVALID), 32'd1);
    resp = bus.S_AXI_BRESP;
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    check({tag, " bvalid cleared"}, 32'(bus.S_AXI_BVALID), 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0;
    bus.S_AXI_WVALID  = 1'b0; bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0;
    bus.S_AXI_RREADY  = 1'b0;
    tick();
    tick();

    check("reset arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    check("reset awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    check("reset wready",  32'(bus.S_AXI_WREADY),  32'd0);
    check("reset rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
    check("reset bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    check("reset rdata",   bus.S_AXI_RDATA,        32'd0);
    check("reset resps",   32'({bus.S_AXI_BRESP, bus.S_AXI_RRESP}), 32'd0);

    RST = 1'b0;
    tick();
    check("boot arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    check("boot awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    check("boot wready",  32'(bus.S_AXI_WREADY),  32'd1);

    dut.d_data[0]    <= 32'h0000_00AB;
    dut.d_data[1023] <= 32'h5A5A_5A5A;
    dut.i_data[2]    <= 32'h00A0_0283;
    dut.i_data[1023] <= 32'h0102_0304;
    tick();

    axi_read("rd d0", 32'h0000_0000, rd, rs);
    check("rd d0 data", rd, 32'h0000_00AB);
    check("rd d0 resp", 32'(rs), 32'(RESP_OKAY));

    axi_read("rd i2", 32'h0000_1008, rd, rs);
    check("rd i2 data", rd, 32'h00A0_0283);
    check("rd i2 resp", 32'(rs), 32'(RESP_OKAY));

    axi_read("rd i2 low bits", 32'h0000_100B, rd, rs);
    check("rd i2 low bits data", rd, 32'h00A0_0283);

    axi_read("rd d last", 32'h0000_0FFC, rd, rs);
    check("rd d last data", rd, 32'h5A5A_5A5A);
    check("rd d last resp", 32'(rs), 32'(RESP_OKAY));

    axi_read("rd 2000", 32'h0000_2000, rd, rs);
    check("rd 2000 data", rd, 32'd0);
    check("rd 2000 resp", 32'(rs), 32'(RESP_SLVERR));

    // Byte-lane write over a known word.
    dut.d_data[0] <= 32'h1122_3344;
    tick();
    axi_write("wr strb1", 32'h0000_0000, 32'h0000_00CD, 4'b0001, bs);
    check("wr strb1 resp", 32'(bs), 32'(RESP_OKAY));
    axi_read("rd after strb1", 32'h0000_0000, rd, rs);
    check("rd after strb1 data", rd, 32'h1122_33CD);

    // AW leads W by three cycles; response then held under BREADY=0.
    bus.S_AXI_AWADDR  = 32'h0000_0004;
    bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    check("split awready dropped", 32'(bus.S_AXI_AWREADY), 32'd0);
    check("split wready still up", 32'(bus.S_AXI_WREADY),  32'd1);
    for (int c = 0; c < 3; c++) begin
      check("split no bvalid before W", 32'(bus.S_AXI_BVALID), 32'd0);
      tick();
    end
    bus.S_AXI_WDATA  = 32'hDEAD_BEEF;
    bus.S_AXI_WSTRB  = 4'b1111;
    bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    check("split wready dropped", 32'(bus.S_AXI_WREADY), 32'd0);
    n = 0;
    while (!bus.S_AXI_BVALID && n < 20) begin
      tick();
      n++;
    end
    check("split bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    check("split bresp", 32'(bus.S_AXI_BRESP), 32'(RESP_OKAY));
    for (int c = 0; c < 2; c++) begin
      tick();
      check("split bvalid held", 32'(bus.S_AXI_BVALID), 32'd1);
      check("split awready held low", 32'(bus.S_AXI_AWREADY), 32'd0);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    check("split bvalid cleared", 32'(bus.S_AXI_BVALID), 32'd0);
    check("split awready back", 32'(bus.S_AXI_AWREADY), 32'd1);
    check("split wready back", 32'(bus.S_AXI_WREADY), 32'd1);
    axi_read("rd split", 32'h0000_0004, rd, rs);
    check("rd split data", rd, 32'hDEAD_BEEF);

    axi_read("rd oor", 32'h0000_8000, rd, rs);
    check("rd oor data", rd, 32'd0);
    check("rd oor resp", 32'(rs), 32'(RESP_SLVERR));
    axi_write("wr oor", 32'h0000_8000, 32'hFFFF_FFFF, 4'b1111, bs);
    check("wr oor resp", 32'(bs), 32'(RESP_SLVERR));
    axi_read("rd after oor", 32'h0000_0000, rd, rs);
    check("rd after oor data", rd, 32'h1122_33CD);

    axi_write("wr strb0", 32'h0000_0004, 32'h0000_0000, 4'b0000, bs);
    check("wr strb0 resp", 32'(bs), 32'(RESP_OKAY));
    axi_read("rd after strb0", 32'h0000_0004, rd, rs);
    check("rd after strb0 data", rd, 32'hDEAD_BEEF);

    axi_write("wr i last", 32'h0000_1FFC, 32'hAAAA_5555, 4'b1100, bs);
    check("wr i last resp", 32'(bs), 32'(RESP_OKAY));
    axi_read("rd i last", 32'h0000_1FFC, rd, rs);
    check("rd i last data", rd, 32'hAAAA_0304);

    // Reset while a read response is pending.
    bus.S_AXI_ARADDR  = 32'h0000_1008;
    bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    check("mid rvalid up", 32'(bus.S_AXI_RVALID), 32'd1);
    RST = 1'b1;
    #1;
    check("mid rvalid dropped", 32'(bus.S_AXI_RVALID), 32'd0);
    check("mid arready low", 32'(bus.S_AXI_ARREADY), 32'd0);
    tick();
    RST = 1'b0;
    tick();
    check("post reset arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    axi_read("rd post reset", 32'h0000_1008, rd, rs);
    check("rd post reset data", rd, 32'h00A0_0283);
    axi_read("rd post reset d0", 32'h0000_0000, rd, rs);
    check("rd post reset d0 data", rd, 32'h1122_33CD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_memory_mock.md
Name: axi_lite_memory_mock

Overview:
- Simulation-only AXI4-Lite slave that models the core's instruction and data memories.
- Two word arrays, named exactly `i_data` (instruction) and `d_data` (data). Testbenches preload them hierarchically with $readmemh after reset.
- Sits on the core-side M_AXI bus of cm_and_core and serves both instruction fetches and load/store traffic.

Parameters:
- ADDR_WIDTH, 32, AXI address width (matches `AXI_ADDR_WIDTH).
- DATA_WIDTH, 32, AXI data width; strobe width is DATA_WIDTH/8.
- D_BASE, 32'h0000_0000, byte base address of `d_data`.
- D_DEPTH, 1024, `d_data` depth in 32-bit words.
- I_BASE, 32'h0000_1000, byte base address of `i_data`.
- I_DEPTH, 1024, `i_data` depth in 32-bit words.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_AWADDR  in  ADDR_WIDTH  write byte address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_WDATA  in  DATA_WIDTH  write data.
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte-lane enables.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_ARADDR  in  ADDR_WIDTH  read byte address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- S_AXI_RDATA  out  DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.

Behaviour:
- Address decode uses the word index (addr−base)>>2; address bits [1:0] are ignored.
  - `d_data` covers [D_BASE, D_BASE+4·D_DEPTH).
  - `i_data` covers [I_BASE, I_BASE+4·I_DEPTH).
  - Any other address is out of range.
- Reset (async assert, sync release):
  - All VALIDs, all READYs, RDATA, BRESP and RRESP go to 0.
  - Capture flags are cleared.
  - Memory contents are NOT touched by reset.
- First rising edge after reset release: AWREADY, WREADY and ARREADY go to 1.
- Read channel (one outstanding read):
  - ARREADY=1 while no read response is pending.
  - On the edge where ARVALID&&ARREADY:
    - RDATA is loaded from the addressed word, sampled at that edge (old data if a write commits on the same edge).
    - RRESP=OKAY (2'b00) in range; SLVERR (2'b10) with RDATA=0 when out of range.
    - RVALID=1 and ARREADY=0 on that same edge.
  - RVALID and RDATA stay stable until RVALID&&RREADY; on that edge RVALID=0 and ARREADY=1.
  - Latency: RVALID is visible one cycle after the AR handshake.
- Write channel (one outstanding write):
  - AW and W are accepted independently, in either order or on the same edge.
  - AWREADY drops on the edge where AW is captured; WREADY drops on the edge where W is captured.
  - On the first edge where both address and data are held:
    - Bytes with WSTRB[i]=1 are written to the addressed word; other bytes are unchanged.
    - BVALID=1, with BRESP=OKAY in range.
    - Out-of-range writes: no memory change, BRESP=SLVERR.
  - BVALID holds until BVALID&&BREADY; on that edge BVALID=0 and AWREADY=WREADY=1.
  - No new AW or W is accepted while a response is pending.
- Read and write channels are fully independent and may be active in the same cycle.
- WSTRB=0 gives an OKAY response with no memory change.
- Reset asserted mid-transaction aborts it: VALIDs drop immediately; any write not yet committed is lost.
- Writes to `i_data` are permitted (self-modifying and test loading allowed).

Decomposition:
- AXI widths, PROT width and response codes (OKAY=2'b00, SLVERR=2'b10) come from the shared axi_configuration header/package; no local redefinition.
- Single flat module; no sub-module needed.

Test Plan:
- Reset then preload `d_data[0]`=0x000000AB; read 0x0000 -> RVALID one cycle after AR handshake, RDATA=0x000000AB, RRESP=OKAY.
- Preload `i_data[2]`=0x00A00283; read 0x1008 -> RDATA=0x00A00283, OKAY.
- Write 0x0000 data 0x000000CD WSTRB=4'b0001 over 0x11223344 -> subsequent read returns 0x112233CD, BRESP=OKAY.
- AW presented 3 cycles before W -> AWREADY drops after AW; BVALID only after W handshake; BVALID held across 2 cycles of BREADY=0.
- Read 0x8000 and write 0x8000 -> RRESP=SLVERR, RDATA=0; BRESP=SLVERR; memory unchanged.
- Assert RST while RVALID=1 -> RVALID=0 immediately; after release ARREADY=1 and preloaded contents intact.
